// File: rtl/memory_word_loader.sv
// Byte-serial memory read sequencer feeding the Data Register: fetches 1/2/4 bytes
// MSB-first and steers DR_I/DR_E/DR_FunSel so the extended value assembles in DROut.
module memory_word_loader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic [1:0]            Size,
  input  logic                  SignExt,
  input  logic                  LittleEnd,
  input  logic [7:0]            MemData,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemRead,
  output logic [7:0]            DR_I,
  output logic                  DR_E,
  output logic [1:0]            DR_FunSel,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int              CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            left_q, left_d;
  logic                  sign_q, sign_d;
  logic                  little_q, little_d;
  logic                  first_q, first_d;
  logic                  mem_read_q, mem_read_d;
  logic [7:0]            dr_i_q, dr_i_d;
  logic                  dr_e_q, dr_e_d;
  logic [1:0]            dr_funsel_q, dr_funsel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [1:0] req_left;

  always_comb begin
    case (Size)
      2'b00:   req_left = 2'd0;
      2'b01:   req_left = 2'd1;
      default: req_left = 2'd3;
    endcase
  end

  // Little-endian operands start at the highest address so the MSB byte always arrives first.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    sign_d      = sign_q;
    little_d    = little_q;
    first_d     = first_q;
    mem_read_d  = mem_read_q;
    dr_i_d      = dr_i_q;
    dr_e_d      = 1'b0;
    dr_funsel_d = dr_funsel_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Size == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d    = REQ;
            left_d     = req_left;
            sign_d     = SignExt;
            little_d   = LittleEnd;
            first_d    = 1'b1;
            cnt_d      = '0;
            mem_read_d = 1'b1;
            addr_d     = LittleEnd ? BaseAddr + ADDR_WIDTH'(req_left) : BaseAddr;
          end
        end
      end
      REQ: begin
        if (cnt_q == LAST_CNT) begin
          state_d     = LOAD;
          mem_read_d  = 1'b0;
          dr_i_d      = MemData;
          dr_e_d      = 1'b1;
          dr_funsel_d = first_q ? (sign_q ? 2'b00 : 2'b01) : 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        first_d = 1'b0;
        if (left_q != 2'd0) begin
          state_d    = REQ;
          left_d     = left_q - 2'd1;
          cnt_d      = '0;
          mem_read_d = 1'b1;
          addr_d     = little_q ? addr_q - 1'b1 : addr_q + 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      left_q      <= 2'd0;
      sign_q      <= 1'b0;
      little_q    <= 1'b0;
      first_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      dr_i_q      <= 8'h00;
      dr_e_q      <= 1'b0;
      dr_funsel_q <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      sign_q      <= sign_d;
      little_q    <= little_d;
      first_q     <= first_d;
      mem_read_q  <= mem_read_d;
      dr_i_q      <= dr_i_d;
      dr_e_q      <= dr_e_d;
      dr_funsel_q <= dr_funsel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign MemAddr   = addr_q;
  assign MemRead   = mem_read_q;
  assign DR_I      = dr_i_q;
  assign DR_E      = dr_e_q;
  assign DR_FunSel = dr_funsel_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_memory_word_loader.sv
// Bench for memory_word_loader: two instances (latency 1 and 3) share stimulus and are
// compared every cycle against a cycle-count model, plus hand-computed DROut/timing values.
module tb_memory_word_loader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] BaseAddr;
  logic [1:0]  Size;
  logic        SignExt;
  logic        LittleEnd;

  logic [7:0]  mem_data  [2];
  logic [15:0] mem_addr  [2];
  logic        mem_read  [2];
  logic [7:0]  dr_i      [2];
  logic        dr_e      [2];
  logic [1:0]  dr_fs     [2];
  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];

  logic [7:0]  mem [0:65535];
  int          rd_cnt [2];
  logic [31:0] dr [2];
  int          done_cnt [2];

  int checks = 0;
  int errors = 0;
  int txn_count = 0;
  logic chk_en = 1'b0;

  // model state and expected outputs
  logic        m_act [2];
  int          m_t [2];
  int          m_n [2];
  logic [15:0] m_base [2];
  logic        m_sign [2];
  logic        m_little [2];
  logic        e_read [2];
  logic [15:0] e_addr [2];
  logic        e_e [2];
  logic [7:0]  e_i [2];
  logic [1:0]  e_fs [2];
  logic        e_busy [2];
  logic        e_done [2];
  logic        e_err [2];

  always #5 Clock = ~Clock;

  memory_word_loader #(.ADDR_WIDTH(16), .MEM_LATENCY(1)) u_lat1 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr), .Size(Size),
    .SignExt(SignExt), .LittleEnd(LittleEnd), .MemData(mem_data[0]),
    .MemAddr(mem_addr[0]), .MemRead(mem_read[0]), .DR_I(dr_i[0]), .DR_E(dr_e[0]),
    .DR_FunSel(dr_fs[0]), .Busy(busy[0]), .Done(done[0]), .Err(err[0])
  );

  memory_word_loader #(.ADDR_WIDTH(16), .MEM_LATENCY(3)) u_lat3 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr), .Size(Size),
    .SignExt(SignExt), .LittleEnd(LittleEnd), .MemData(mem_data[1]),
    .MemAddr(mem_addr[1]), .MemRead(mem_read[1]), .DR_I(dr_i[1]), .DR_E(dr_e[1]),
    .DR_FunSel(dr_fs[1]), .Busy(busy[1]), .Done(done[1]), .Err(err[1])
  );

  // Memory returns garbage until the read has been held for the full latency.
  assign mem_data[0] = mem_read[0] ? mem[mem_addr[0]] : 8'hA5;
  assign mem_data[1] = (mem_read[1] && rd_cnt[1] >= 2) ? mem[mem_addr[1]] : 8'hA5;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_cnt[0] <= 0;
      rd_cnt[1] <= 0;
    end else begin
      rd_cnt[0] <= mem_read[0] ? rd_cnt[0] + 1 : 0;
      rd_cnt[1] <= mem_read[1] ? rd_cnt[1] + 1 : 0;
    end
  end

  // Data Register receiver: 00 load sign-extended, 01 load zero-extended, 10 shift in.
  always @(posedge Clock) begin
    for (int d = 0; d < 2; d++) begin
      if (dr_e[d] === 1'b1) begin
        case (dr_fs[d])
          2'b00:   dr[d] <= {{24{dr_i[d][7]}}, dr_i[d]};
          2'b01:   dr[d] <= {24'h000000, dr_i[d]};
          2'b10:   dr[d] <= {dr[d][23:0], dr_i[d]};
          default: dr[d] <= dr[d];
        endcase
      end
    end
  end

  always @(posedge Clock) begin
    for (int d = 0; d < 2; d++)
      if (done[d] === 1'b1) done_cnt[d] <= done_cnt[d] + 1;
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int size_to_n(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [15:0] byte_addr(input logic [15:0] base, input int n,
                                            input logic little, input int j);
    return little ? base + 16'(n - 1 - j) : base + 16'(j);
  endfunction

  function automatic logic [31:0] exp_dr(input logic [15:0] base, input int n,
                                         input logic sign, input logic little);
    logic [31:0] v;
    v = 32'h0;
    for (int j = 0; j < n; j++)
      v = (v << 8) | {24'h000000, mem[byte_addr(base, n, little, j)]};
    if (sign && n < 4 && v[n*8-1]) v = v | (32'hFFFFFFFF << (n * 8));
    return v;
  endfunction

  function automatic logic [31:0] outs(input int d);
    return {1'b0, mem_addr[d], dr_i[d], dr_fs[d], dr_e[d], mem_read[d], busy[d], done[d], err[d]};
  endfunction

  // Reference model: position within a transfer is derived from the cycle count since T0.
  initial begin
    int L, k, j, ph;
    logic [15:0] a;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_t[d] = 0; m_n[d] = 1; m_base[d] = 16'h0;
      m_sign[d] = 1'b0; m_little[d] = 1'b0;
      e_read[d] = 1'b0; e_addr[d] = 16'h0; e_e[d] = 1'b0; e_i[d] = 8'h00;
      e_fs[d] = 2'b00; e_busy[d] = 1'b0; e_done[d] = 1'b0; e_err[d] = 1'b0;
    end
    forever begin
      @(posedge Clock or negedge Reset);
      for (int d = 0; d < 2; d++) begin
        L = lat(d);
        if (!Reset) begin
          m_act[d] = 1'b0; m_t[d] = 0;
          e_read[d] = 1'b0; e_addr[d] = 16'h0; e_e[d] = 1'b0; e_i[d] = 8'h00;
          e_fs[d] = 2'b00; e_busy[d] = 1'b0; e_done[d] = 1'b0; e_err[d] = 1'b0;
        end else begin
          e_err[d] = 1'b0;
          if (m_act[d]) begin
            if (m_t[d] == m_n[d] * (L + 1) + 1) m_act[d] = 1'b0;
            else m_t[d] = m_t[d] + 1;
          end else if (Start) begin
            if (Size == 2'b11) begin
              e_err[d] = 1'b1;
            end else begin
              m_act[d] = 1'b1; m_t[d] = 1; m_n[d] = size_to_n(Size);
              m_base[d] = BaseAddr; m_sign[d] = SignExt; m_little[d] = LittleEnd;
            end
          end
          e_read[d] = 1'b0; e_e[d] = 1'b0; e_done[d] = 1'b0;
          if (m_act[d]) begin
            k = m_t[d] - 1; j = k / (L + 1); ph = k % (L + 1);
            if (j < m_n[d]) begin
              a = byte_addr(m_base[d], m_n[d], m_little[d], j);
              if (ph < L) begin
                e_read[d] = 1'b1; e_addr[d] = a;
              end else begin
                e_e[d] = 1'b1; e_i[d] = mem[a];
                e_fs[d] = (j == 0) ? (m_sign[d] ? 2'b00 : 2'b01) : 2'b10;
              end
            end else begin
              e_done[d] = 1'b1;
            end
          end
          e_busy[d] = m_act[d];
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    logic [31:0] act, exp;
    forever begin
      @(negedge Clock);
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          act = {1'b0, e_read[d] ? mem_addr[d] : 16'h0, dr_i[d], dr_fs[d], dr_e[d],
                 mem_read[d], busy[d], done[d], err[d]};
          exp = {1'b0, e_read[d] ? e_addr[d] : 16'h0, e_i[d], e_fs[d], e_e[d],
                 e_read[d], e_busy[d], e_done[d], e_err[d]};
          checks++;
          if (act !== exp) begin
            errors++;
            $display("[TB] FAIL cycle_lat%0d @%0t: got {addr,i,fs,e,rd,busy,done,err}=0x%08h, expected 0x%08h",
                     lat(d), $time, act, exp);
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input string name, input logic [15:0] base, input logic [1:0] size,
                                input logic sign, input logic little, input logic [31:0] exp_lit,
                                input int c1, input int c3, input bit poke);
    int cyc;
    int dcyc [2];
    int n;
    n = size_to_n(size);
    dcyc[0] = 0; dcyc[1] = 0;
    @(negedge Clock);
    BaseAddr = base; Size = size; SignExt = sign; LittleEnd = little; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0; BaseAddr = ~base; Size = 2'b11; SignExt = ~sign; LittleEnd = ~little;
    txn_count++;
    check_output({name, "_model"}, exp_dr(base, n, sign, little), exp_lit);
    cyc = 1;
    while (cyc <= 40 && (dcyc[0] == 0 || dcyc[1] == 0)) begin
      if (poke && cyc == 3) begin
        Start = 1'b1; BaseAddr = 16'h0020; Size = 2'b01;
      end else begin
        Start = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        if (done[d] === 1'b1 && dcyc[d] == 0) begin
          dcyc[d] = cyc;
          check_output($sformatf("%s_drout_lat%0d", name, lat(d)), dr[d], exp_lit);
        end
      end
      @(negedge Clock);
      cyc++;
    end
    Start = 1'b0;
    check_output({name, "_done_cycle_lat1"}, 32'(dcyc[0]), 32'(c1));
    check_output({name, "_done_cycle_lat3"}, 32'(dcyc[1]), 32'(c3));
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; BaseAddr = 16'h0; Size = 2'b00; SignExt = 1'b0; LittleEnd = 1'b0;
    dr[0] = 32'h0; dr[1] = 32'h0; done_cnt[0] = 0; done_cnt[1] = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h12; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h56; mem[16'h0013] = 8'h78;
    mem[16'h0020] = 8'h34; mem[16'h0021] = 8'hF2;
    mem[16'h0030] = 8'h80;
    mem[16'hFFFE] = 8'hDE; mem[16'hFFFF] = 8'hAD; mem[16'h0000] = 8'hBE; mem[16'h0001] = 8'hEF;

    repeat (2) @(negedge Clock);
    chk_en = 1'b1;
    check_output("reset_outputs_lat1", outs(0), 32'h0);
    check_output("reset_outputs_lat3", outs(1), 32'h0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    apply_stimulus("be_word",      16'h0010, 2'b10, 1'b0, 1'b0, 32'h12345678, 9, 17, 1'b0);
    apply_stimulus("le_shalf",     16'h0020, 2'b01, 1'b1, 1'b1, 32'hFFFFF234, 5, 9, 1'b0);
    apply_stimulus("ubyte",        16'h0030, 2'b00, 1'b0, 1'b0, 32'h00000080, 3, 5, 1'b0);
    apply_stimulus("sbyte",        16'h0030, 2'b00, 1'b1, 1'b0, 32'hFFFFFF80, 3, 5, 1'b0);
    apply_stimulus("wrap_word",    16'hFFFE, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 9, 17, 1'b0);
    apply_stimulus("busy_ignored", 16'h0010, 2'b10, 1'b1, 1'b0, 32'h12345678, 9, 17, 1'b1);

    // illegal size: Err pulse in the next cycle, nothing else moves
    @(negedge Clock);
    Start = 1'b1; Size = 2'b11; BaseAddr = 16'h0010;
    @(negedge Clock);
    Start = 1'b0; Size = 2'b00;
    check_output("illegal_err_lat1", {30'h0, busy[0], err[0]}, 32'h1);
    check_output("illegal_err_lat3", {30'h0, busy[1], err[1]}, 32'h1);
    @(negedge Clock);
    check_output("illegal_after_lat1", {29'h0, mem_read[0], busy[0], err[0]}, 32'h0);

    // reset in the middle of a word, after the second LOAD of the latency-1 instance
    @(negedge Clock);
    BaseAddr = 16'h0010; Size = 2'b10; SignExt = 1'b0; LittleEnd = 1'b0; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    check_output("midreset_lat1", outs(0), 32'h0);
    check_output("midreset_lat3", outs(1), 32'h0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    apply_stimulus("after_reset",  16'h0010, 2'b10, 1'b0, 1'b0, 32'h12345678, 9, 17, 1'b0);

    repeat (3) @(negedge Clock);
    check_output("done_count_lat1", 32'(done_cnt[0]), 32'(txn_count));
    check_output("done_count_lat3", 32'(done_cnt[1]), 32'(txn_count));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
